// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - pipelined opcode decode stage with ID/EX register and hazard control
//
// Decodes the 6-bit primary opcode into the datapath control bundle and
// registers it at the ID/EX boundary. It inserts bubbles for load-use
// hazards, jump shadows, flushes and idle input cycles. It holds the output
// register while the downstream stage stalls.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   res       - synchronous active-high reset
//   in_valid  - upstream instruction fields are valid
//   in_ready  - stage accepts the instruction this cycle (combinational)
//   opcode    - instruction[31:26]
//   rs/rt/rd  - register specifiers from the instruction
//   stall_in  - downstream not ready, hold the output register
//   flush     - taken branch resolved in EX, squash this stage
//   out_valid - registered bundle holds a real instruction
//   ALUOp, RegDest, RegWrite, ALUSrc, MemRead, MemWrite, MemToReg,
//   Branch, Jump, out_dst, illegal - registered decode results
module ctrl_decode_stage #(
  parameter int ALUOP_W        = 3,
  parameter int REG_ADDR_W     = 5,
  parameter int JUMP_BUBBLES   = 1,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            opcode,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [ALUOP_W-1:0]    ALUOp,
  output logic                  RegDest,
  output logic                  RegWrite,
  output logic                  ALUSrc,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  MemToReg,
  output logic                  Branch,
  output logic                  Jump,
  output logic [REG_ADDR_W-1:0] out_dst,
  output logic                  illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_ADDIU = 6'b001001;

  // Control bit positions: RegDest RegWrite ALUSrc MemRead MemWrite MemToReg Branch Jump
  localparam int C_MEMREAD = 4;

  typedef enum logic {ST_RUN, ST_JBUB} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic [ALUOP_W-1:0]     alu_q, alu_d;
  logic [7:0]             ctrl_q, ctrl_d;
  logic [REG_ADDR_W-1:0]  dst_q, dst_d;
  logic                   ill_q, ill_d;

  logic [2:0]             dec_alu;
  logic [7:0]             dec_ctrl;
  logic [REG_ADDR_W-1:0]  dec_dst;
  logic                   dec_ill;
  logic                   reads_rt;
  logic                   hazard;

  always_comb begin
    dec_alu  = 3'b000;
    dec_ctrl = 8'b0000_0000;
    dec_dst  = '0;
    dec_ill  = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin dec_alu = 3'b010; dec_ctrl = 8'b1100_0000; dec_dst = rd; end
      OP_LW:    begin dec_alu = 3'b000; dec_ctrl = 8'b0111_0100; dec_dst = rt; end
      OP_SW:    begin dec_alu = 3'b000; dec_ctrl = 8'b0010_1000; end
      OP_BEQ:   begin dec_alu = 3'b001; dec_ctrl = 8'b0000_0010; end
      OP_J:     begin dec_alu = 3'b000; dec_ctrl = 8'b0000_0001; end
      OP_ADDI:  begin dec_alu = 3'b000; dec_ctrl = 8'b0110_0000; dec_dst = rt; end
      OP_ANDI:  begin dec_alu = 3'b011; dec_ctrl = 8'b0110_0000; dec_dst = rt; end
      OP_ORI:   begin dec_alu = 3'b100; dec_ctrl = 8'b0110_0000; dec_dst = rt; end
      OP_XORI:  begin dec_alu = 3'b110; dec_ctrl = 8'b0110_0000; dec_dst = rt; end
      OP_ADDIU: begin dec_alu = 3'b111; dec_ctrl = 8'b0110_0000; dec_dst = rt; end
      default:  dec_ill = 1'b1;
    endcase
  end

  // Only R-type, beq and sw actually read rt as a source; for the other
  // formats rt is a destination and cannot create a load-use dependency.
  assign reads_rt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_SW);

  assign hazard = (LOAD_USE_STALL != 0) && valid_q && ctrl_q[C_MEMREAD] &&
                  (dst_q != '0) && ((dst_q == rs) || ((dst_q == rt) && reads_rt));

  assign in_ready = (state_q == ST_RUN) && !stall_in && !flush && !hazard;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    alu_d   = alu_q;
    ctrl_d  = ctrl_q;
    dst_d   = dst_q;
    ill_d   = ill_q;
    if (flush) begin
      state_d = ST_RUN;
      cnt_d   = 3'd0;
      valid_d = 1'b0; alu_d = '0; ctrl_d = '0; dst_d = '0; ill_d = 1'b0;
    end else if (stall_in) begin
      // hold everything, including the bubble counter
    end else if (state_q == ST_JBUB) begin
      valid_d = 1'b0; alu_d = '0; ctrl_d = '0; dst_d = '0; ill_d = 1'b0;
      cnt_d   = cnt_q - 3'd1;
      if (cnt_q <= 3'd1) begin
        state_d = ST_RUN;
        cnt_d   = 3'd0;
      end
    end else if (in_valid && in_ready) begin
      valid_d = 1'b1;
      alu_d   = ALUOP_W'(dec_alu);
      ctrl_d  = dec_ctrl;
      dst_d   = dec_dst;
      ill_d   = dec_ill;
      if ((opcode == OP_J) && (JUMP_BUBBLES > 0)) begin
        state_d = ST_JBUB;
        cnt_d   = 3'(JUMP_BUBBLES);
      end
    end else begin
      // hazard or idle input: load a bubble
      valid_d = 1'b0; alu_d = '0; ctrl_d = '0; dst_d = '0; ill_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      alu_q   <= '0;
      ctrl_q  <= '0;
      dst_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      alu_q   <= alu_d;
      ctrl_q  <= ctrl_d;
      dst_q   <= dst_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid = valid_q;
  assign ALUOp     = alu_q;
  assign RegDest   = ctrl_q[7];
  assign RegWrite  = ctrl_q[6];
  assign ALUSrc    = ctrl_q[5];
  assign MemRead   = ctrl_q[4];
  assign MemWrite  = ctrl_q[3];
  assign MemToReg  = ctrl_q[2];
  assign Branch    = ctrl_q[1];
  assign Jump      = ctrl_q[0];
  assign out_dst   = dst_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb/tb_ctrl_decode_stage.sv - scoreboard testbench for ctrl_decode_stage
module tb_ctrl_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res, in_valid, stall_in, flush;
  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;

  logic       in_ready_a, out_valid_a, illegal_a;
  logic [4:0] ALUOp_a, out_dst_a;
  logic       RegDest_a, RegWrite_a, ALUSrc_a, MemRead_a, MemWrite_a, MemToReg_a, Branch_a, Jump_a;

  logic       in_ready_b, out_valid_b, illegal_b;
  logic [2:0] ALUOp_b;
  logic [4:0] out_dst_b;
  logic       RegDest_b, RegWrite_b, ALUSrc_b, MemRead_b, MemWrite_b, MemToReg_b, Branch_b, Jump_b;

  ctrl_decode_stage #(.ALUOP_W(5), .REG_ADDR_W(5), .JUMP_BUBBLES(2), .LOAD_USE_STALL(1)) dut_a (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready_a), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .stall_in(stall_in), .flush(flush), .out_valid(out_valid_a),
    .ALUOp(ALUOp_a), .RegDest(RegDest_a), .RegWrite(RegWrite_a), .ALUSrc(ALUSrc_a),
    .MemRead(MemRead_a), .MemWrite(MemWrite_a), .MemToReg(MemToReg_a), .Branch(Branch_a),
    .Jump(Jump_a), .out_dst(out_dst_a), .illegal(illegal_a)
  );

  ctrl_decode_stage #(.ALUOP_W(3), .REG_ADDR_W(5), .JUMP_BUBBLES(0), .LOAD_USE_STALL(0)) dut_b (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready_b), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .stall_in(stall_in), .flush(flush), .out_valid(out_valid_b),
    .ALUOp(ALUOp_b), .RegDest(RegDest_b), .RegWrite(RegWrite_b), .ALUSrc(ALUSrc_b),
    .MemRead(MemRead_b), .MemWrite(MemWrite_b), .MemToReg(MemToReg_b), .Branch(Branch_b),
    .Jump(Jump_b), .out_dst(out_dst_b), .illegal(illegal_b)
  );

  // Packed view: {valid, illegal, dst[4:0], aluop[4:0], RegDest..Jump}
  logic [19:0] obs_a, obs_b;
  assign obs_a = {out_valid_a, illegal_a, out_dst_a, ALUOp_a, RegDest_a, RegWrite_a, ALUSrc_a,
                  MemRead_a, MemWrite_a, MemToReg_a, Branch_a, Jump_a};
  assign obs_b = {out_valid_b, illegal_b, out_dst_b, 2'b00, ALUOp_b, RegDest_b, RegWrite_b,
                  ALUSrc_b, MemRead_b, MemWrite_b, MemToReg_b, Branch_b, Jump_b};

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model, one slot per DUT
  logic [19:0] m_out [2];
  bit          m_jb  [2];
  int          m_cnt [2];
  int          p_jb  [2] = '{2, 0};
  bit          p_lus [2] = '{1'b1, 1'b0};
  logic [19:0] qa[$], qb[$];
  logic        dut_rdy_a;

  function automatic logic [19:0] tb_dec(input logic [5:0] op, input logic [4:0] t, input logic [4:0] d);
    logic [4:0] alu, dst;
    logic [7:0] c;
    logic       ill;
    alu = 5'd0; dst = 5'd0; c = 8'h00; ill = 1'b0;
    case (op)
      6'b000000: begin alu = 5'd2; c = 8'b1100_0000; dst = d; end
      6'b100011: begin alu = 5'd0; c = 8'b0111_0100; dst = t; end
      6'b101011: begin alu = 5'd0; c = 8'b0010_1000; end
      6'b000100: begin alu = 5'd1; c = 8'b0000_0010; end
      6'b000010: begin alu = 5'd0; c = 8'b0000_0001; end
      6'b001000: begin alu = 5'd0; c = 8'b0110_0000; dst = t; end
      6'b001100: begin alu = 5'd3; c = 8'b0110_0000; dst = t; end
      6'b001101: begin alu = 5'd4; c = 8'b0110_0000; dst = t; end
      6'b001110: begin alu = 5'd6; c = 8'b0110_0000; dst = t; end
      6'b001001: begin alu = 5'd7; c = 8'b0110_0000; dst = t; end
      default:   ill = 1'b1;
    endcase
    return {1'b1, ill, dst, alu, c};
  endfunction

  task automatic cyc(input bit r, input bit v, input logic [5:0] op, input logic [4:0] s,
                     input logic [4:0] t, input logic [4:0] d, input bit st, input bit fl);
    bit         rdy [2];
    bit         hz;
    logic [4:0] md;
    @(negedge clk);
    res = r; in_valid = v; opcode = op; rs = s; rt = t; rd = d; stall_in = st; flush = fl;
    #1;
    dut_rdy_a = in_ready_a;
    for (int k = 0; k < 2; k++) begin
      md = m_out[k][17:13];
      hz = p_lus[k] && m_out[k][19] && m_out[k][4] && (md != 5'd0) &&
           ((md == s) || ((md == t) && (op == 6'b000000 || op == 6'b000100 || op == 6'b101011)));
      rdy[k] = !m_jb[k] && !st && !fl && !hz;
    end
    if (!r) begin
      chk("in_ready_a", {31'd0, in_ready_a}, {31'd0, rdy[0]});
      chk("in_ready_b", {31'd0, in_ready_b}, {31'd0, rdy[1]});
    end
    for (int k = 0; k < 2; k++) begin
      if (r || fl) begin
        m_out[k] = '0; m_jb[k] = 1'b0; m_cnt[k] = 0;
      end else if (st) begin
        // hold
      end else if (m_jb[k]) begin
        m_out[k] = '0;
        if (m_cnt[k] == 1) m_jb[k] = 1'b0;
        m_cnt[k]--;
      end else if (v && rdy[k]) begin
        m_out[k] = tb_dec(op, t, d);
        if (k == 1) m_out[k][12:8] = {2'b00, m_out[k][10:8]};
        if (op == 6'b000010 && p_jb[k] > 0) begin m_jb[k] = 1'b1; m_cnt[k] = p_jb[k]; end
      end else begin
        m_out[k] = '0;
      end
    end
    qa.push_back(m_out[0]);
    qb.push_back(m_out[1]);
    @(posedge clk);
    #1;
    if (qa.size() == 0 || qb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      chk("bundle_a", {12'd0, obs_a}, {12'd0, qa.pop_front()});
      chk("bundle_b", {12'd0, obs_b}, {12'd0, qb.pop_front()});
    end
  endtask

  logic [5:0] ops [11] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000,
                           6'b001100, 6'b001101, 6'b001110, 6'b001001, 6'b111111};

  initial begin
    res = 1'b1; in_valid = 1'b0; opcode = '0; rs = '0; rt = '0; rd = '0; stall_in = 1'b0; flush = 1'b0;
    for (int k = 0; k < 2; k++) begin m_out[k] = '0; m_jb[k] = 1'b0; m_cnt[k] = 0; end

    // Reset with a valid lw presented
    cyc(1, 1, 6'b100011, 1, 2, 3, 0, 0);
    cyc(1, 1, 6'b100011, 1, 2, 3, 0, 0);
    chk("rst_out_a", {12'd0, obs_a}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rdy_after_rst", {31'd0, dut_rdy_a}, 32'd1);

    // Decode sweep
    for (int i = 0; i < 11; i++) begin
      cyc(0, 1, ops[i], 5'd20, 5'(i + 1), 5'(31 - i), 0, 0);
      if (ops[i] == 6'b000010) begin cyc(0, 0, 0, 0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0, 0, 0); end
    end
    cyc(0, 1, 6'b001101, 1, 9, 0, 0, 0);
    chk("ori_w5", {27'd0, ALUOp_a}, 32'b00100);
    cyc(0, 1, 6'b001110, 1, 9, 0, 0, 0);
    chk("xori_w5", {27'd0, ALUOp_a}, 32'b00110);

    // Load-use on rs
    cyc(0, 1, 6'b100011, 1, 5, 0, 0, 0);
    cyc(0, 1, 6'b000000, 5, 9, 10, 0, 0);
    chk("lu_stall", {31'd0, dut_rdy_a}, 32'd0);
    cyc(0, 1, 6'b000000, 5, 9, 10, 0, 0);
    chk("lu_issue", {31'd0, dut_rdy_a}, 32'd1);
    chk("lu_rd", {27'd0, out_dst_a}, 32'd10);
    // No dependency
    cyc(0, 1, 6'b100011, 1, 5, 0, 0, 0);
    cyc(0, 1, 6'b000000, 6, 6, 11, 0, 0);
    chk("lu_none", {31'd0, dut_rdy_a}, 32'd1);
    // rt dependency for R-type, none for addi
    cyc(0, 1, 6'b100011, 1, 5, 0, 0, 0);
    cyc(0, 1, 6'b000000, 1, 5, 12, 0, 0);
    cyc(0, 1, 6'b000000, 1, 5, 12, 0, 0);
    cyc(0, 1, 6'b100011, 1, 5, 0, 0, 0);
    cyc(0, 1, 6'b001000, 1, 5, 0, 0, 0);
    chk("lu_addi_rt", {31'd0, dut_rdy_a}, 32'd1);

    // Jump bubbles
    cyc(0, 1, 6'b000010, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 6'b001000, 2, 7, 0, 0, 0);
    // Jump with stall mid-shadow
    cyc(0, 1, 6'b000010, 0, 0, 0, 0, 0);
    cyc(0, 1, 6'b001000, 2, 7, 0, 0, 0);
    cyc(0, 1, 6'b001000, 2, 7, 0, 1, 0);
    cyc(0, 1, 6'b001000, 2, 7, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 6'b001000, 2, 7, 0, 0, 0);

    // Flush during JBUB, then flush with a valid instruction
    cyc(0, 1, 6'b000010, 0, 0, 0, 0, 0);
    cyc(0, 1, 6'b001000, 2, 7, 0, 0, 1);
    cyc(0, 1, 6'b001000, 2, 7, 0, 0, 1);
    chk("flush_rdy", {31'd0, dut_rdy_a}, 32'd0);
    cyc(0, 1, 6'b001100, 2, 8, 0, 0, 0);
    chk("post_flush", {31'd0, dut_rdy_a}, 32'd1);
    // Flush coinciding with a jump: no shadow
    cyc(0, 1, 6'b000010, 0, 0, 0, 0, 1);
    cyc(0, 1, 6'b001000, 2, 7, 0, 0, 0);
    chk("flush_j_rdy", {31'd0, dut_rdy_a}, 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 10)];
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) != 0), op,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
- Parametrised, pipelined successor to the single-cycle opcode decoder.
- Decodes the 6-bit primary opcode into the datapath control bundle and registers it into the ID/EX boundary, with a valid/ready handshake.
- Adds behaviour the plain decoder lacks: load-use hazard stall, jump bubble insertion, flush from EX, downstream stall, and illegal-opcode flagging.
- Sits between the IF/ID register and the execute stage.

Parameters:
ALUOP_W, 3, width of ALUOp output; must be >= 3; codes are zero-extended.
REG_ADDR_W, 5, register-specifier width for rs/rt/rd/out_dst.
JUMP_BUBBLES, 1, bubble cycles inserted after a jump is accepted; range 0..7.
LOAD_USE_STALL, 1, 1 enables load-use hazard bubbles; 0 disables them.

Ports:
clk  input  1  clock; all state updates on rising edge.
res  input  1  synchronous active-high reset.
in_valid  input  1  upstream instruction fields valid.
in_ready  output  1  stage accepts the instruction this cycle (combinational).
opcode  input  6  instruction[31:26].
rs  input  REG_ADDR_W  source register 1.
rt  input  REG_ADDR_W  source register 2 / I-type destination.
rd  input  REG_ADDR_W  R-type destination.
stall_in  input  1  downstream not ready; hold the output register.
flush  input  1  taken branch resolved in EX; squash this stage.
out_valid  output  1  registered bundle holds a real instruction.
ALUOp  output  ALUOP_W  ALU operation class.
RegDest, RegWrite, ALUSrc, MemRead, MemWrite, MemToReg, Branch, Jump  output  1 each  registered control signals.
out_dst  output  REG_ADDR_W  registered destination register.
illegal  output  1  registered flag; accepted opcode was not decodable.

Behaviour:
- Reset (`res` high at edge): all outputs 0, state RUN, bubble counter 0. Reset overrides flush and stall, and aborts any pending bubbles.
- Decode table (ALUOp, RegDest, RegWrite, ALUSrc, MemRead, MemWrite, MemToReg, Branch, Jump):
  - R-type 000000: 010,1,1,0,0,0,0,0,0
  - lw 100011: 000,0,1,1,1,0,1,0,0
  - sw 101011: 000,0,0,1,0,1,0,0,0
  - beq 000100: 001,0,0,0,0,0,0,1,0
  - j 000010: 000,0,0,0,0,0,0,0,1
  - addi 001000: 000,0,1,1,0,0,0,0,0
  - andi 001100: 011,0,1,1,0,0,0,0,0
  - ori 001101: 100,0,1,1,0,0,0,0,0
  - xori 001110: 110,0,1,1,0,0,0,0,0
  - addiu 001001: 111,0,1,1,0,0,0,0,0
- No X values anywhere; every don't-care is driven 0.
- Any other opcode: all controls 0, illegal=1, out_valid=1.
- out_dst: rd for R-type; rt for lw/addi/addiu/andi/ori/xori; 0 otherwise.
- Bubble: out_valid=0, all controls 0, out_dst=0, illegal=0.
- Latency: accepted instruction (in_valid && in_ready at edge) appears on outputs immediately after that edge.
- Hazard (only when LOAD_USE_STALL=1): current out_valid && MemRead && out_dst!=0, and either
  - out_dst==rs, or
  - out_dst==rt with opcode in {R-type, beq, sw}.
- in_ready = state==RUN && !stall_in && !flush && !hazard.
- Priority at each edge: res > flush > stall_in > hazard > normal.
  - flush: output loads bubble; state RUN; counter 0; input not accepted.
  - stall_in (no flush): output register and counter hold.
  - hazard: output loads bubble for one cycle. The following cycle out is no longer lw, so the instruction is accepted.
  - RUN, no in_valid: output loads bubble.
- FSM states RUN and JBUB:
  - Accepting j with JUMP_BUBBLES>0: go to JBUB, counter=JUMP_BUBBLES.
  - JBUB: each non-stalled cycle loads a bubble and decrements the counter; at counter==1 go to RUN.
  - JUMP_BUBBLES=0: JBUB is never entered.
- Simultaneous flush and jump acceptance: flush wins; no JBUB entry.

Test Plan:
- Reset: res=1 for 2 cycles with in_valid=1, opcode=100011 -> all outputs 0; in_ready=1 after res drops.
- Decode sweep: feed each of the 10 opcodes, then 111111, one per cycle -> bundles match the table one cycle later; 111111 gives illegal=1, out_valid=1, controls 0.
- Load-use stall: lw rt=5, then R-type rs=5 -> one bubble (in_ready=0 one cycle), then R-type issues with RegDest=1, out_dst=rd. Same pair with rs=rt=6 -> no bubble. LOAD_USE_STALL=0 -> no bubble.
- Jump bubbles with JUMP_BUBBLES=2: j then addi -> j bundle, then 2 bubbles, then addi. Hold stall_in=1 mid-sequence -> output and counter frozen.
- Flush during JBUB, and flush with in_valid=1 -> output bubble next cycle, in_ready=1 the cycle after, next instruction decoded normally.
- Width: ALUOP_W=5 -> ori yields ALUOp=00100, xori yields 00110.
